// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// XLEN/MXLEN/trap_cause_t match the core's privilege definitions.
package trap_ctrl_pkg;

    localparam int XLEN  = 32;
    localparam int MXLEN = 32;

    typedef logic [4:0] trap_cause_t;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STATUS,
        T_JUMP,
        R_STATUS,
        R_JUMP
    } trap_ctrl_state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;

    function automatic logic [MXLEN-1:0] mstatus_on_trap(input logic [MXLEN-1:0] m);
        logic [MXLEN-1:0] r;
        r = m;
        r[MSTATUS_MPIE_BIT]         = m[MSTATUS_MIE_BIT];
        r[MSTATUS_MIE_BIT]          = 1'b0;
        r[MSTATUS_MPP_LSB +: 2]     = 2'b11;
        return r;
    endfunction

    function automatic logic [MXLEN-1:0] mstatus_on_mret(input logic [MXLEN-1:0] m);
        logic [MXLEN-1:0] r;
        r = m;
        r[MSTATUS_MIE_BIT]          = m[MSTATUS_MPIE_BIT];
        r[MSTATUS_MPIE_BIT]         = 1'b1;
        r[MSTATUS_MPP_LSB +: 2]     = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl_vec_calc.sv
// Trap target from mtvec: direct base, or base + 4*cause for vectored interrupts.
// Latency: combinational.
// Backpressure: none.
module trap_vec_calc
    import trap_ctrl_pkg::*;
#(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic [MXLEN-1:0] mtvec,
    input  trap_cause_t      cause,
    input  logic             intr,
    output logic [XLEN-1:0]  target
);

    logic [MXLEN-1:0] base;
    logic [MXLEN-1:0] offset;

    always_comb begin
        base   = {mtvec[MXLEN-1:2], 2'b00};
        offset = '0;
        offset[$bits(trap_cause_t)+1:2] = cause;
        target = XLEN'(base);
        // MODE values 2 and 3 are reserved and fall back to direct.
        if (VECTORED_EN && intr && (mtvec[1:0] == 2'b01)) begin
            target = XLEN'(base + offset);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt/MRET sequencer: one CSR write per cycle, then redirect + flush.
// Latency: trap/irq redirect 5 cycles after acceptance, MRET redirect 2 cycles after.
// Backpressure: o_busy stalls the pipeline; requests are only sampled in IDLE.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter bit MTVEC_VECTORED_EN = 1'b1,
    parameter bit RESET_STALL       = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_trap_req,
    input  trap_cause_t       i_trap_cause,
    input  logic [MXLEN-1:0]  i_trap_tval,
    input  logic [XLEN-1:0]   i_trap_pc,
    input  logic              i_irq_req,
    input  trap_cause_t       i_irq_cause,
    input  logic [XLEN-1:0]   i_irq_pc,
    input  logic              i_mret,
    input  logic [MXLEN-1:0]  i_mtvec,
    input  logic [MXLEN-1:0]  i_mepc,
    input  logic [MXLEN-1:0]  i_mstatus,
    output logic              o_csr_we,
    output logic [11:0]       o_csr_addr,
    output logic [MXLEN-1:0]  o_csr_wdata,
    output logic              o_busy,
    output logic              o_redirect,
    output logic [XLEN-1:0]   o_redirect_pc,
    output logic              o_flush
);

    localparam int CW = $bits(trap_cause_t);

    trap_ctrl_state_t state_q, state_d;
    logic [XLEN-1:0]  pc_q;
    trap_cause_t      cause_q;
    logic [MXLEN-1:0] tval_q;
    logic             intr_q;
    logic             stall_q;
    logic             accept_ok;
    logic             irq_take;
    logic [XLEN-1:0]  vec_target;

    assign accept_ok = (state_q == IDLE) && !stall_q;
    assign irq_take  = i_irq_req && i_mstatus[MSTATUS_MIE_BIT];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            stall_q <= RESET_STALL;
        end else begin
            state_q <= state_d;
            stall_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q    <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            intr_q  <= 1'b0;
        end else if (accept_ok) begin
            if (i_trap_req) begin
                pc_q    <= i_trap_pc;
                cause_q <= i_trap_cause;
                tval_q  <= i_trap_tval;
                intr_q  <= 1'b0;
            end else if (irq_take) begin
                pc_q    <= i_irq_pc;
                cause_q <= i_irq_cause;
                tval_q  <= '0;
                intr_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_ok) begin
                    if (i_trap_req || irq_take) state_d = T_EPC;
                    else if (i_mret)            state_d = R_STATUS;
                end
            end
            T_EPC:    state_d = T_CAUSE;
            T_CAUSE:  state_d = T_TVAL;
            T_TVAL:   state_d = T_STATUS;
            T_STATUS: state_d = T_JUMP;
            T_JUMP:   state_d = IDLE;
            R_STATUS: state_d = R_JUMP;
            R_JUMP:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    trap_vec_calc #(
        .VECTORED_EN (MTVEC_VECTORED_EN)
    ) u_vec_calc (
        .mtvec  (i_mtvec),
        .cause  (cause_q),
        .intr   (intr_q),
        .target (vec_target)
    );

    always_comb begin
        o_csr_we      = 1'b0;
        o_csr_addr    = '0;
        o_csr_wdata   = '0;
        o_redirect    = 1'b0;
        o_redirect_pc = '0;
        o_flush       = 1'b0;
        // The post-reset stall bit is set during reset, so mask it there.
        o_busy        = (state_q != IDLE) || (stall_q && !i_rst);
        unique case (state_q)
            T_EPC: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MEPC;
                o_csr_wdata = MXLEN'({pc_q[XLEN-1:2], 2'b00});
            end
            T_CAUSE: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MCAUSE;
                o_csr_wdata = {intr_q, {(MXLEN-1-CW){1'b0}}, cause_q};
            end
            T_TVAL: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MTVAL;
                o_csr_wdata = tval_q;
            end
            T_STATUS: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MSTATUS;
                o_csr_wdata = mstatus_on_trap(i_mstatus);
            end
            R_STATUS: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MSTATUS;
                o_csr_wdata = mstatus_on_mret(i_mstatus);
            end
            T_JUMP: begin
                o_redirect    = 1'b1;
                o_flush       = 1'b1;
                o_redirect_pc = vec_target;
            end
            R_JUMP: begin
                o_redirect    = 1'b1;
                o_flush       = 1'b1;
                o_redirect_pc = XLEN'({i_mepc[MXLEN-1:2], 2'b00});
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected CSR writes/redirects,
// a negedge monitor pops and compares every DUT output event.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              trap_req = 1'b0;
    trap_cause_t       trap_cause = '0;
    logic [MXLEN-1:0]  trap_tval = '0;
    logic [XLEN-1:0]   trap_pc = '0;
    logic              irq_req = 1'b0;
    trap_cause_t       irq_cause = '0;
    logic [XLEN-1:0]   irq_pc = '0;
    logic              mret = 1'b0;
    logic [MXLEN-1:0]  mtvec = '0;
    logic [MXLEN-1:0]  mepc = '0;
    logic [MXLEN-1:0]  mstatus = '0;
    logic              csr_we;
    logic [11:0]       csr_addr;
    logic [MXLEN-1:0]  csr_wdata;
    logic              busy;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              flush;

    typedef struct {
        bit          redir;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    trap_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_trap_req    (trap_req),
        .i_trap_cause  (trap_cause),
        .i_trap_tval   (trap_tval),
        .i_trap_pc     (trap_pc),
        .i_irq_req     (irq_req),
        .i_irq_cause   (irq_cause),
        .i_irq_pc      (irq_pc),
        .i_mret        (mret),
        .i_mtvec       (mtvec),
        .i_mepc        (mepc),
        .i_mstatus     (mstatus),
        .o_csr_we      (csr_we),
        .o_csr_addr    (csr_addr),
        .o_csr_wdata   (csr_wdata),
        .o_busy        (busy),
        .o_redirect    (redirect),
        .o_redirect_pc (redirect_pc),
        .o_flush       (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (csr_we || redirect)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: we=%0b addr=0x%03h wdata=0x%08h redirect=%0b pc=0x%08h, expected none",
                         csr_we, csr_addr, csr_wdata, redirect, redirect_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.redir) begin
                    check("redirect_strobe", {31'd0, redirect}, 32'd1);
                    check("redirect_we",     {31'd0, csr_we},   32'd0);
                    check("redirect_flush",  {31'd0, flush},    32'd1);
                    check("redirect_pc",     redirect_pc,       e.data);
                end else begin
                    check("csr_we",    {31'd0, csr_we},  32'd1);
                    check("csr_addr",  {20'd0, csr_addr}, {20'd0, e.addr});
                    check("csr_wdata", csr_wdata,        e.data);
                end
            end
        end
    end

    function automatic void push_w(input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        e.redir = 1'b0; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void push_r(input logic [31:0] pc);
        exp_t e;
        e.redir = 1'b1; e.addr = '0; e.data = pc;
        exp_q.push_back(e);
    endfunction

    function automatic void push_trap(input logic [31:0] epc, input logic [31:0] cause_w,
                                      input logic [31:0] tval, input logic [31:0] mst,
                                      input logic [31:0] target);
        push_w(12'h341, epc);
        push_w(12'h342, cause_w);
        push_w(12'h343, tval);
        push_w(12'h300, mst);
        push_r(target);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles until the DUT returns to IDLE; bounded.
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
    endtask

    int n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_we",       {31'd0, csr_we},   32'd0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_flush",    {31'd0, flush},    32'd0);
        step(); step();
        rst = 1'b0;
        step();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Illegal instruction, direct mtvec.
        mtvec = 32'h200; mstatus = 32'h8;
        push_trap(32'h104, 32'h2, 32'h13, 32'h1880, 32'h200);
        trap_req = 1'b1; trap_cause = 5'd2; trap_tval = 32'h13; trap_pc = 32'h104;
        step();
        trap_req = 1'b0;
        wait_idle(n);
        check("trap_busy_cycles", n, 5);

        // Vectored interrupt.
        mtvec = 32'h201; mstatus = 32'h8;
        push_trap(32'h400, 32'h80000007, 32'h0, 32'h1880, 32'h21C);
        irq_req = 1'b1; irq_cause = 5'd7; irq_pc = 32'h400;
        step();
        irq_req = 1'b0;
        wait_idle(n);
        check("irq_busy_cycles", n, 5);

        // Reserved MODE=3 behaves as direct; low pc bits are cleared in mepc.
        mtvec = 32'h303;
        push_trap(32'h400, 32'h80000003, 32'h0, 32'h1880, 32'h300);
        irq_req = 1'b1; irq_cause = 5'd3; irq_pc = 32'h403;
        step();
        irq_req = 1'b0;
        wait_idle(n);
        check("mode3_busy_cycles", n, 5);

        // Masked interrupt: nothing happens.
        mstatus = 32'h0; irq_req = 1'b1; irq_cause = 5'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("masked_busy", {31'd0, busy}, 32'd0);
        end
        step();
        irq_req = 1'b0;

        // MRET.
        mepc = 32'h106; mstatus = 32'h80;
        push_w(12'h300, 32'h1888);
        push_r(32'h104);
        mret = 1'b1;
        step();
        mret = 1'b0;
        wait_idle(n);
        check("mret_busy_cycles", n, 2);

        // Priority: trap beats irq and mret; held irq taken afterwards.
        mtvec = 32'h201; mstatus = 32'h8;
        push_trap(32'h500, 32'hB, 32'h0, 32'h1880, 32'h200);
        push_trap(32'h600, 32'h80000007, 32'h0, 32'h1880, 32'h21C);
        trap_req = 1'b1; trap_cause = 5'd11; trap_tval = 32'h0; trap_pc = 32'h500;
        irq_req = 1'b1; irq_cause = 5'd7; irq_pc = 32'h600;
        mret = 1'b1;
        step();
        trap_req = 1'b0; mret = 1'b0;
        wait_idle(n);
        check("prio_trap_cycles", n, 5);
        step();
        irq_req = 1'b0;
        wait_idle(n);
        check("prio_irq_cycles", n, 5);

        // Reset during T_CAUSE aborts the sequence.
        mtvec = 32'h200; mstatus = 32'h8;
        push_w(12'h341, 32'h700);
        push_w(12'h342, 32'h5);
        trap_req = 1'b1; trap_cause = 5'd5; trap_tval = 32'hDEAD; trap_pc = 32'h700;
        step();
        trap_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy",     {31'd0, busy},     32'd0);
        check("abort_we",       {31'd0, csr_we},   32'd0);
        check("abort_redirect", {31'd0, redirect}, 32'd0);
        check("abort_flush",    {31'd0, flush},    32'd0);
        check("abort_wdata",    csr_wdata,         32'd0);
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_abort_busy", {31'd0, busy}, 32'd0);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
